// File: rtl/scan_sequencer.sv
// Raster-scan sequencer: lead-in, active and trail-out rows of programmable width,
// driving per-pixel qualifiers and coordinates from internal X/Y counters.
module scan_sequencer #(
  parameter int X_W = 10,
  parameter int Y_W = 10,
  parameter int M_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [X_W-1:0] cfg_width,
  input  logic [Y_W-1:0] cfg_height,
  input  logic [M_W-1:0] cfg_lead,
  input  logic [M_W-1:0] cfg_trail,
  output logic           row_start,
  output logic           row_end,
  output logic           pixel_valid,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_done,
  output logic           idle
);

  // state  | meaning
  // IDLE   | waiting for start; frame_done pulses here after a frame
  // LEAD   | scanning lead-in rows, pixel_valid low
  // ACTIVE | scanning active rows, pixel_valid high, y = row index
  // TRAIL  | scanning trail-out rows, pixel_valid low
  typedef enum logic [1:0] {IDLE, LEAD, ACTIVE, TRAIL} state_t;

  localparam int RC_W = (Y_W > M_W) ? Y_W : M_W;

  state_t         state, state_nx;
  logic [X_W-1:0] w_sh;
  logic [Y_W-1:0] h_sh;
  logic [M_W-1:0] t_sh;
  logic [RC_W-1:0] rc, rc_nx;
  logic [X_W-1:0] x_nx, x_inc;
  logic [Y_W-1:0] y_nx;
  logic           rs_nx, re_nx, pv_nx, fd_nx;
  logic           accept, last_col;

  assign idle     = (state == IDLE);
  assign x_inc    = x + X_W'(1);
  assign last_col = (x == w_sh - X_W'(1));
  assign accept   = (state == IDLE) && start && !abort &&
                    (cfg_width != '0) && (cfg_height != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rc          <= '0;
      x           <= '0;
      y           <= '0;
      row_start   <= 1'b0;
      row_end     <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      w_sh        <= '0;
      h_sh        <= '0;
      t_sh        <= '0;
    end else begin
      state       <= state_nx;
      rc          <= rc_nx;
      x           <= x_nx;
      y           <= y_nx;
      row_start   <= rs_nx;
      row_end     <= re_nx;
      pixel_valid <= pv_nx;
      frame_done  <= fd_nx;
      if (accept) begin
        w_sh <= cfg_width;
        h_sh <= cfg_height;
        t_sh <= cfg_trail;
      end
    end
  end

  // rc counts rows remaining in the current phase; zero marks its final row
  always_comb begin
    state_nx = state;
    rc_nx    = rc;
    x_nx     = '0;
    y_nx     = '0;
    rs_nx    = 1'b0;
    re_nx    = 1'b0;
    pv_nx    = 1'b0;
    fd_nx    = 1'b0;
    if (state == IDLE) begin
      if (accept) begin
        rs_nx = 1'b1;
        re_nx = (cfg_width == X_W'(1));
        if (cfg_lead != '0) begin
          state_nx = LEAD;
          rc_nx    = RC_W'(cfg_lead) - RC_W'(1);
        end else begin
          state_nx = ACTIVE;
          rc_nx    = RC_W'(cfg_height) - RC_W'(1);
          pv_nx    = 1'b1;
        end
      end
    end else if (abort) begin
      state_nx = IDLE;
      rc_nx    = '0;
    end else if (!last_col) begin
      x_nx  = x_inc;
      y_nx  = y;
      re_nx = (x_inc == w_sh - X_W'(1));
      pv_nx = (state == ACTIVE);
    end else if (rc != '0) begin
      rc_nx = rc - RC_W'(1);
      rs_nx = 1'b1;
      re_nx = (w_sh == X_W'(1));
      pv_nx = (state == ACTIVE);
      y_nx  = (state == ACTIVE) ? y + Y_W'(1) : '0;
    end else begin
      rs_nx = 1'b1;
      re_nx = (w_sh == X_W'(1));
      case (state)
        LEAD: begin
          state_nx = ACTIVE;
          rc_nx    = RC_W'(h_sh) - RC_W'(1);
          pv_nx    = 1'b1;
        end
        ACTIVE: begin
          if (t_sh != '0) begin
            state_nx = TRAIL;
            rc_nx    = RC_W'(t_sh) - RC_W'(1);
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
      if (state_nx == IDLE) begin
        rs_nx = 1'b0;
        re_nx = 1'b0;
        fd_nx = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: per-cycle comparison of all outputs
// against a closed-form expectation of the raster position.
module tb_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [9:0] cfg_width, cfg_height;
  logic [2:0] cfg_lead, cfg_trail;
  logic       row_start, row_end, pixel_valid, frame_done, idle;
  logic [9:0] x, y;

  int n_checks = 0;
  int n_errors = 0;

  scan_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_lead(cfg_lead), .cfg_trail(cfg_trail),
    .row_start(row_start), .row_end(row_end), .pixel_valid(pixel_valid),
    .x(x), .y(y), .frame_done(frame_done), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] dut_vec();
    return {row_start, row_end, pixel_valid, x, y, frame_done, idle};
  endfunction

  localparam logic [24:0] IDLE_VEC = 25'h1;

  // Expected outputs at cycle c of a frame whose start was sampled at cycle 0
  function automatic logic [24:0] exp_vec(input int w, h, l, t, c);
    int f, p, xe, row, ye;
    logic rs, re, pv;
    logic [9:0] xv, yv;
    f = w * (l + h + t);
    if (c == f + 1) return 25'h3;
    if (c < 1 || c > f + 1) return IDLE_VEC;
    p   = c - 1;
    xe  = p % w;
    row = p / w;
    rs  = (xe == 0);
    re  = (xe == w - 1);
    pv  = (row >= l) && (row < l + h);
    ye  = pv ? row - l : 0;
    xv  = xe[9:0];
    yv  = ye[9:0];
    return {rs, re, pv, xv, yv, 1'b0, 1'b0};
  endfunction

  task automatic scan(input string name, input int w, h, l, t, from, to);
    for (int c = from; c <= to; c++) begin
      check($sformatf("%s c%0d", name, c), dut_vec(), exp_vec(w, h, l, t, c));
      tick();
    end
  endtask

  task automatic set_cfg(input int w, h, l, t);
    cfg_width  = w[9:0];
    cfg_height = h[9:0];
    cfg_lead   = l[2:0];
    cfg_trail  = t[2:0];
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(4, 3, 1, 2);
    tick(); tick();
    check("reset", dut_vec(), IDLE_VEC);
    rst = 1'b0;
    tick();

    // W=4 H=3 L=1 T=2: 24 scan cycles then frame_done
    start = 1'b1;
    scan("basic", 4, 3, 1, 2, 0, 0);
    start = 1'b0;
    scan("basic", 4, 3, 1, 2, 1, 26);

    // W=1, no lead/trail
    set_cfg(1, 5, 0, 0);
    start = 1'b1;
    scan("w1", 1, 5, 0, 0, 0, 0);
    start = 1'b0;
    scan("w1", 1, 5, 0, 0, 1, 7);

    // zero width / zero height start requests are ignored
    start = 1'b1;
    set_cfg(0, 3, 1, 2);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("zero_w %0d", i), dut_vec(), IDLE_VEC);
      tick();
    end
    set_cfg(4, 0, 1, 2);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("zero_h %0d", i), dut_vec(), IDLE_VEC);
      tick();
    end
    start = 1'b0;

    // abort together with start in IDLE
    set_cfg(4, 3, 1, 2);
    start = 1'b1; abort = 1'b1;
    tick();
    check("abort_start", dut_vec(), IDLE_VEC);
    start = 1'b0; abort = 1'b0;
    tick();

    // abort at cycle 10, restart at cycle 11
    start = 1'b1;
    scan("abort", 4, 3, 1, 2, 0, 0);
    start = 1'b0;
    scan("abort", 4, 3, 1, 2, 1, 9);
    abort = 1'b1;
    scan("abort", 4, 3, 1, 2, 10, 10);
    abort = 1'b0; start = 1'b1;
    check("abort c11", dut_vec(), IDLE_VEC);
    tick();
    start = 1'b0;
    scan("restart", 4, 3, 1, 2, 1, 26);

    // start held high: back-to-back frames, width change latched only at next start
    start = 1'b1;
    scan("b2b_a", 4, 3, 1, 2, 0, 25);
    scan("b2b_b", 4, 3, 1, 2, 1, 10);
    cfg_width = 10'd7;
    scan("b2b_b", 4, 3, 1, 2, 11, 25);
    start = 1'b0;
    scan("b2b_c", 7, 3, 1, 2, 1, 44);

    // rst mid-frame at cycle 8, start ignored while rst high
    set_cfg(4, 3, 1, 2);
    start = 1'b1;
    scan("rst", 4, 3, 1, 2, 0, 0);
    start = 1'b0;
    scan("rst", 4, 3, 1, 2, 1, 7);
    rst = 1'b1; start = 1'b1;
    scan("rst", 4, 3, 1, 2, 8, 8);
    check("rst c9", dut_vec(), IDLE_VEC);
    tick();
    check("rst c10", dut_vec(), IDLE_VEC);
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst release", dut_vec(), IDLE_VEC);
    tick();
    check("rst settle", dut_vec(), IDLE_VEC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Parametrised raster-scan sequencer and successor to the fixed two-row-margin frame engine. It owns internal X/Y counters, so it needs no external near-end inputs. Each frame consists of a programmable number of lead-in rows, active rows and trail-out rows, all of a programmable width. It sits between the frame-start control logic and the pixel datapath, and drives per-pixel qualifiers and coordinates.

Parameters:
X_W, 10, width of column counter and cfg_width
Y_W, 10, width of row counter and cfg_height
M_W, 3, width of lead/trail row-count configuration

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  frame start request, sampled only in IDLE
abort  in  1  synchronous frame abort
cfg_width  in  X_W  pixels per row, must be >=1
cfg_height  in  Y_W  active rows, must be >=1
cfg_lead  in  M_W  rows scanned before active rows (0 allowed)
cfg_trail  in  M_W  rows scanned after active rows (0 allowed)
row_start  out  1  high on first cycle (x==0) of every scanned row
row_end  out  1  high on last cycle (x==W-1) of every scanned row
pixel_valid  out  1  high on every cycle of active rows
x  out  X_W  column index of current cycle
y  out  Y_W  active-row index; 0 outside ACTIVE
frame_done  out  1  single-cycle pulse after normal frame completion
idle  out  1  high when state==IDLE

Behaviour:
- Reset: state IDLE; x=0, y=0; row_start, row_end, pixel_valid, frame_done all 0; idle=1. All outputs except idle are registered; idle is decoded from the state register.
- States: IDLE, LEAD, ACTIVE, TRAIL.
- IDLE: on start=1, abort=0, cfg_width!=0 and cfg_height!=0:
  - latch all cfg_* into shadow registers; cfg changes mid-frame have no effect.
  - next state is LEAD if cfg_lead!=0, else ACTIVE.
  - start with a zero width or height is ignored: stay IDLE, no pulse.
- Latency: start sampled at edge N -> cycle N+1 is the first scan cycle, with x=0 and row_start=1.
- Scanning, all of LEAD, ACTIVE and TRAIL:
  - x increments every cycle, with no gap cycles between rows.
  - at x==W-1: row_end=1; next cycle x=0 and row_start=1.
  - W==1: row_start and row_end are both high every cycle.
- LEAD: after cfg_lead complete rows -> ACTIVE. pixel_valid=0, y=0.
- ACTIVE: pixel_valid=1 on every cycle.
  - y = active row index 0..H-1; increments at row boundaries.
  - after H rows: -> TRAIL if cfg_trail!=0, else IDLE.
- TRAIL: after cfg_trail rows -> IDLE. pixel_valid=0, y=0.
- Frame length is exactly W*(L+H+T) cycles.
- Completion: frame_done=1 in the first IDLE cycle after the last scan cycle. start in that same cycle is accepted, giving a minimum 1-cycle gap between frames.
- start outside IDLE is ignored.
- abort=1 in any scan state:
  - next cycle IDLE with all outputs cleared.
  - frame_done stays 0.
  - abort in the last scan cycle also suppresses frame_done.
- abort=1 together with start in IDLE: abort wins, frame not started.
- rst mid-frame: same as the reset values above, next cycle.
- Counters: the row counter is wide enough for max(Y_W, M_W) and is reloaded on each phase entry. There is no overflow because lengths are bounded by the latched cfg values.

Test Plan:
- W=4,H=3,L=1,T=2, start pulse at cycle 0:
  - scan cycles 1..24; row_start at 1,5,...,21; row_end at 4,8,...,24.
  - pixel_valid on cycles 5..16 with y=0,0,0,0,1,...,2.
  - frame_done at cycle 25, idle=1 from cycle 25.
- L=0,T=0,W=1,H=5:
  - pixel_valid cycles 1..5, y=0..4.
  - row_start=row_end=1 each cycle.
  - frame_done at cycle 6.
- start with cfg_width=0, or with cfg_height=0 -> idle stays 1 and no output toggles for 20 cycles.
- Abort handling:
  - abort at cycle 10 of the W=4,H=3,L=1,T=2 frame -> cycle 11 idle=1 and all outputs 0; frame_done never asserted.
  - new start at cycle 11 -> frame runs normally.
- Back-to-back and config latching:
  - start held high continuously -> frames of 24 cycles separated by exactly one IDLE cycle with frame_done=1.
  - cfg_width changed to 7 mid-frame -> current frame unaffected; next frame uses 7.
- rst asserted at cycle 8 mid-frame -> cycle 9 shows the reset values; start in IDLE is ignored while rst=1.
